// File: rtl/sram_cfg_master.sv
// ---------------------------------------------------------------------------
// sram_cfg_master
//
// Avalon-MM master that stands in for the host on the SRAM controller's
// eight-register slave port. A single start pulse programs one test run,
// polls the status register until the run completes, reads back the result
// registers and then clears the send/enable bits again.
//
// Bus sequence for one run:
//   a0 <= cfg_sta_addr, a1 <= cfg_area, a2 <= cfg_op, a4 <= 1, a3 <= 1,
//   read a7 until bit DONE_BIT is set, read a5, read a6,
//   a3 <= 0, a4 <= 0, one-cycle done pulse.
// Every accepted transfer is followed by one idle bus cycle.
//
// Parameters:
//   DONE_BIT  bit of the status register (reg 7) that flags run complete
//   POLL_MAX  status reads allowed before timeout (timeout build only)
//
// Optional feature (macro SRAM_CFG_MASTER_TIMEOUT_EN):
//   defined   : poll counter; after POLL_MAX status reads without DONE_BIT
//               the result reads are skipped, error is set and the clear
//               writes still run.
//   undefined : polling never gives up, error is tied to 0.
//
// Ports:
//   avalon_clk      clock, rising edge
//   reset_n         asynchronous active-low reset
//   start           one-cycle run request, honoured only when idle
//   cfg_sta_addr    value written to reg 0
//   cfg_area        value written to reg 1
//   cfg_op          value written to reg 2
//   chipselect, address, write, writedata, read   Avalon master outputs
//   readdata, waitrequest                         Avalon slave responses
//   busy            high while a run is in progress
//   done            one-cycle completion pulse
//   error           sticky timeout flag, cleared by the next start
//   res_addr        captured reg 5
//   res_data        captured reg 6
//   res_status      last captured reg 7
// ---------------------------------------------------------------------------
module sram_cfg_master #(
  parameter int DONE_BIT = 0,
  parameter int POLL_MAX = 1024
) (
  input  logic        avalon_clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [31:0] cfg_sta_addr,
  input  logic [31:0] cfg_area,
  input  logic [31:0] cfg_op,
  output logic        chipselect,
  output logic [2:0]  address,
  output logic        write,
  output logic [31:0] writedata,
  output logic        read,
  input  logic [31:0] readdata,
  input  logic        waitrequest,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [31:0] res_addr,
  output logic [31:0] res_data,
  output logic [31:0] res_status
);

  typedef enum logic [3:0] {
    IDLE,
    W_STA,
    W_AREA,
    W_OP,
    W_EN,
    W_SEND,
    POLL,
    R_ADDR,
    R_DATA,
    C_SEND,
    C_EN,
    FIN
  } state_t;

  state_t      state;
  // Set for the single idle bus cycle that follows every accepted transfer;
  // the transfer belonging to 'state' is launched when it clears.
  logic        gap;
  logic        accept;
  logic [31:0] area_q;
  logic [31:0] op_q;

  assign accept = chipselect & ~waitrequest;

`ifdef SRAM_CFG_MASTER_TIMEOUT_EN
  localparam int POLL_CNT_W = $clog2(POLL_MAX + 1);
  localparam logic [POLL_CNT_W-1:0] POLL_LIMIT = POLL_CNT_W'(POLL_MAX);

  logic [POLL_CNT_W-1:0] poll_cnt;
  logic [POLL_CNT_W-1:0] poll_cnt_nxt;
  logic                  error_q;

  assign poll_cnt_nxt = poll_cnt + 1'b1;
  assign error        = error_q;
`else
  assign error = 1'b0;
`endif

  // Configuration words for the later writes are frozen when the run is
  // accepted; reg 0 is written straight from cfg_sta_addr at that edge.
  always_ff @(posedge avalon_clk) begin
    if (state == IDLE && start) begin
      area_q <= cfg_area;
      op_q   <= cfg_op;
    end
  end

  always_ff @(posedge avalon_clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      gap        <= 1'b0;
      chipselect <= 1'b0;
      address    <= 3'd0;
      write      <= 1'b0;
      writedata  <= 32'd0;
      read       <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      res_addr   <= 32'd0;
      res_data   <= 32'd0;
      res_status <= 32'd0;
`ifdef SRAM_CFG_MASTER_TIMEOUT_EN
      poll_cnt   <= '0;
      error_q    <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state      <= W_STA;
            chipselect <= 1'b1;
            write      <= 1'b1;
            read       <= 1'b0;
            address    <= 3'd0;
            writedata  <= cfg_sta_addr;
            busy       <= 1'b1;
`ifdef SRAM_CFG_MASTER_TIMEOUT_EN
            poll_cnt   <= '0;
            error_q    <= 1'b0;
`endif
          end
        end

        FIN: begin
          // start is deliberately not looked at here
          state <= IDLE;
        end

        default: begin
          if (gap) begin
            // Idle cycle over: launch the transfer of the current state.
            gap        <= 1'b0;
            chipselect <= 1'b1;
            case (state)
              W_AREA: begin
                address   <= 3'd1;
                writedata <= area_q;
                write     <= 1'b1;
              end
              W_OP: begin
                address   <= 3'd2;
                writedata <= op_q;
                write     <= 1'b1;
              end
              W_EN: begin
                address   <= 3'd4;
                writedata <= 32'd1;
                write     <= 1'b1;
              end
              W_SEND: begin
                address   <= 3'd3;
                writedata <= 32'd1;
                write     <= 1'b1;
              end
              POLL: begin
                address <= 3'd7;
                read    <= 1'b1;
              end
              R_ADDR: begin
                address <= 3'd5;
                read    <= 1'b1;
              end
              R_DATA: begin
                address <= 3'd6;
                read    <= 1'b1;
              end
              C_SEND: begin
                address   <= 3'd3;
                writedata <= 32'd0;
                write     <= 1'b1;
              end
              C_EN: begin
                address   <= 3'd4;
                writedata <= 32'd0;
                write     <= 1'b1;
              end
              default: begin
                chipselect <= 1'b0;
              end
            endcase
          end else if (accept) begin
            // Transfer accepted: drop the strobes (address and writedata
            // keep their value) and insert the idle cycle.
            chipselect <= 1'b0;
            write      <= 1'b0;
            read       <= 1'b0;
            gap        <= 1'b1;
            case (state)
              W_STA:  state <= W_AREA;
              W_AREA: state <= W_OP;
              W_OP:   state <= W_EN;
              W_EN:   state <= W_SEND;
              W_SEND: state <= POLL;
              POLL: begin
                res_status <= readdata;
`ifdef SRAM_CFG_MASTER_TIMEOUT_EN
                poll_cnt   <= poll_cnt_nxt;
`endif
                if (readdata[DONE_BIT]) begin
                  state <= R_ADDR;
`ifdef SRAM_CFG_MASTER_TIMEOUT_EN
                end else if (poll_cnt_nxt == POLL_LIMIT) begin
                  // Give up: keep the old results, flag it, still clean up.
                  error_q <= 1'b1;
                  state   <= C_SEND;
`endif
                end else begin
                  state <= POLL;
                end
              end
              R_ADDR: begin
                res_addr <= readdata;
                state    <= R_DATA;
              end
              R_DATA: begin
                res_data <= readdata;
                state    <= C_SEND;
              end
              C_SEND: state <= C_EN;
              C_EN: begin
                // Last transfer goes straight to the done cycle, no gap.
                gap   <= 1'b0;
                busy  <= 1'b0;
                done  <= 1'b1;
                state <= FIN;
              end
              default: state <= IDLE;
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_cfg_master.sv
// Testbench for sram_cfg_master: behavioural Avalon slave, transaction log
// and a reference model that derives the expected bus sequence, results and
// completion cycle from the programming rules of one run.
module tb_sram_cfg_master;

  localparam int PMAX = 4;

  logic        avalon_clk = 1'b0;
  logic        reset_n    = 1'b0;
  logic        start      = 1'b0;
  logic [31:0] cfg_sta_addr = 32'd0;
  logic [31:0] cfg_area     = 32'd0;
  logic [31:0] cfg_op       = 32'd0;
  logic        chipselect, write, read, waitrequest, busy, done, error;
  logic [2:0]  address;
  logic [31:0] writedata, readdata, res_addr, res_data, res_status;

  always #5 avalon_clk = ~avalon_clk;

  sram_cfg_master #(.DONE_BIT(0), .POLL_MAX(PMAX)) dut (
    .avalon_clk  (avalon_clk),
    .reset_n     (reset_n),
    .start       (start),
    .cfg_sta_addr(cfg_sta_addr),
    .cfg_area    (cfg_area),
    .cfg_op      (cfg_op),
    .chipselect  (chipselect),
    .address     (address),
    .write       (write),
    .writedata   (writedata),
    .read        (read),
    .readdata    (readdata),
    .waitrequest (waitrequest),
    .busy        (busy),
    .done        (done),
    .error       (error),
    .res_addr    (res_addr),
    .res_data    (res_data),
    .res_status  (res_status)
  );

  int vectors     = 0;
  int miscompares = 0;

  // ---------------- behavioural slave ----------------
  int txn_idx = 0, poll_idx = 0, stall_cnt = 0;
  int txn_base = 0, poll_base = 0;
  int stall_txn = -1, stall_n = 0, n_clear = 0;
  logic [31:0] clr_val = 32'd0, done_val = 32'd1, r5 = 32'd0, r6 = 32'd0;

  assign waitrequest = chipselect && ((txn_idx - txn_base) == stall_txn) && (stall_cnt < stall_n);

  always_comb begin
    readdata = 32'hDEAD_BEEF;
    if (address == 3'd7)      readdata = ((poll_idx - poll_base) < n_clear) ? clr_val : done_val;
    else if (address == 3'd5) readdata = r5;
    else if (address == 3'd6) readdata = r6;
  end

  always @(posedge avalon_clk) begin
    if (chipselect) begin
      if (waitrequest) stall_cnt <= stall_cnt + 1;
      else begin
        stall_cnt <= 0;
        txn_idx   <= txn_idx + 1;
        if (read && address == 3'd7) poll_idx <= poll_idx + 1;
      end
    end else begin
      stall_cnt <= 0;
    end
  end

  // ---------------- bus monitor ----------------
  logic [36:0] log_q[$];
  logic [36:0] exp_q[$];
  int   gap_viol = 0, done_cnt = 0, hold_cnt = 0;
  logic prev_acc = 1'b0;
  logic [31:0] area_exp = 32'd0;

  always @(negedge avalon_clk) begin
    if (prev_acc && chipselect) gap_viol <= gap_viol + 1;
    prev_acc <= chipselect && !waitrequest;
    if (chipselect && !waitrequest)
      log_q.push_back({address, write, read, (write ? writedata : 32'd0)});
    if (done) done_cnt <= done_cnt + 1;
    if (chipselect && write && address == 3'd1 && writedata == area_exp) hold_cnt <= hold_cnt + 1;
  end

  // ---------------- reference model ----------------
  // Expected accepted transfers of one run: five config writes, the status
  // polls, the two result reads (unless timed out), the two clear writes.
  task automatic build_exp(input logic [31:0] sta, area, op, input int polls, input bit rd);
    exp_q.delete();
    exp_q.push_back({3'd0, 2'b10, sta});
    exp_q.push_back({3'd1, 2'b10, area});
    exp_q.push_back({3'd2, 2'b10, op});
    exp_q.push_back({3'd4, 2'b10, 32'd1});
    exp_q.push_back({3'd3, 2'b10, 32'd1});
    for (int i = 0; i < polls; i++) exp_q.push_back({3'd7, 2'b01, 32'd0});
    if (rd) begin
      exp_q.push_back({3'd5, 2'b01, 32'd0});
      exp_q.push_back({3'd6, 2'b01, 32'd0});
    end
    exp_q.push_back({3'd3, 2'b10, 32'd0});
    exp_q.push_back({3'd4, 2'b10, 32'd0});
  endtask

  // Each transfer costs one cycle plus its idle cycle; the last one's idle
  // slot is the done cycle. Every stall cycle adds one.
  function automatic int exp_done_cycle(input int n_txn, input int stalls);
    return 2 * n_txn + stalls;
  endfunction

  // ---------------- stimulus ----------------
  logic busy_at1, err_at1, busy_at_done;
  int   gap_base, done_base, hold_base;

  task automatic do_run(input logic [31:0] sta, area, op, input int nclr, st_txn, st_n,
                        input int x1, x2, input bit fin_start, output int done_rel);
    log_q.delete();
    txn_base  = txn_idx;
    poll_base = poll_idx;
    n_clear   = nclr;
    stall_txn = st_txn;
    stall_n   = st_n;
    area_exp  = area;
    gap_base  = gap_viol;
    done_base = done_cnt;
    hold_base = hold_cnt;
    done_rel  = -1;
    @(negedge avalon_clk);
    cfg_sta_addr = sta;
    cfg_area     = area;
    cfg_op       = op;
    start        = 1'b1;
    for (int k = 1; k <= 600; k++) begin
      @(negedge avalon_clk);
      cfg_sta_addr = $urandom;
      cfg_area     = $urandom;
      cfg_op       = $urandom;
      if (k == 1) begin
        busy_at1 = busy;
        err_at1  = error;
      end
      if (done) begin
        done_rel     = k;
        busy_at_done = busy;
        start        = fin_start;
        break;
      end
      start = (k == x1 || k == x2);
    end
    @(negedge avalon_clk);
    start = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    repeat (3) @(negedge avalon_clk);
    vectors++;
    if ({chipselect, write, read, busy, done, error, address, writedata, res_addr, res_data, res_status} !== '0) begin
      miscompares++;
      $display("FAIL rst_hold outputs got cs=%b wr=%b rd=%b busy=%b done=%b addr=%0d wd=%h required all 0",
               chipselect, write, read, busy, done, address, writedata);
    end
    reset_n = 1'b1;
    repeat (3) @(negedge avalon_clk);
    vectors++;
    if ({chipselect, write, read, busy, done, error, res_addr, res_data, res_status} !== '0) begin
      miscompares++;
      $display("FAIL rst_release outputs got cs=%b wr=%b rd=%b busy=%b done=%b err=%b required all 0",
               chipselect, write, read, busy, done, error);
    end
  endtask

  task automatic test_zero_wait();
    int dr;
    clr_val = 32'd0; done_val = 32'd1; r5 = 32'hAB; r6 = 32'h5A;
    do_run(32'h10, 32'h20, 32'h3, 0, -1, 0, -1, -1, 1'b0, dr);
    build_exp(32'h10, 32'h20, 32'h3, 1, 1'b1);
    vectors++;
    if (log_q.size() != exp_q.size()) begin
      miscompares++; $display("FAIL zw_len got %0d transfers required %0d", log_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < log_q.size()) begin
      vectors++;
      if (log_q[i] !== exp_q[i]) begin
        miscompares++; $display("FAIL zw_txn%0d got %h required %h", i, log_q[i], exp_q[i]);
      end
    end
    vectors++;
    if (dr != 20) begin miscompares++; $display("FAIL zw_done_cycle got %0d required 20", dr); end
    vectors++;
    if (res_addr !== 32'hAB || res_data !== 32'h5A || res_status !== 32'h1 || error !== 1'b0) begin
      miscompares++;
      $display("FAIL zw_results got addr=%h data=%h status=%h err=%b required ab 5a 1 0", res_addr, res_data, res_status, error);
    end
    vectors++;
    if (busy_at1 !== 1'b1 || busy_at_done !== 1'b0) begin
      miscompares++; $display("FAIL zw_busy got c1=%b fin=%b required 1 0", busy_at1, busy_at_done);
    end
    vectors++;
    if (gap_viol != gap_base) begin miscompares++; $display("FAIL zw_gap got %0d violations required 0", gap_viol - gap_base); end
  endtask

  task automatic test_multi_poll();
    int dr;
    clr_val = $urandom & 32'hFFFF_FFFE; done_val = 32'h1; r5 = $urandom; r6 = $urandom;
    do_run(32'h100, 32'h200, 32'h7, 3, -1, 0, -1, -1, 1'b0, dr);
    build_exp(32'h100, 32'h200, 32'h7, 4, 1'b1);
    vectors++;
    if (log_q.size() != exp_q.size()) begin
      miscompares++; $display("FAIL mp_len got %0d transfers required %0d", log_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < log_q.size()) begin
      vectors++;
      if (log_q[i] !== exp_q[i]) begin
        miscompares++; $display("FAIL mp_txn%0d got %h required %h", i, log_q[i], exp_q[i]);
      end
    end
    vectors++;
    if (dr != 26) begin miscompares++; $display("FAIL mp_done_cycle got %0d required 26", dr); end
    vectors++;
    if (res_status !== 32'h1 || res_addr !== r5 || res_data !== r6) begin
      miscompares++; $display("FAIL mp_results got status=%h addr=%h data=%h required 1 %h %h", res_status, res_addr, res_data, r5, r6);
    end
  endtask

  task automatic test_waitrequest();
    int dr;
    clr_val = 32'd0; done_val = 32'h1; r5 = 32'h1111; r6 = 32'h2222;
    do_run(32'h10, 32'h20, 32'h3, 0, 1, 2, -1, -1, 1'b0, dr);
    build_exp(32'h10, 32'h20, 32'h3, 1, 1'b1);
    vectors++;
    if (hold_cnt - hold_base != 3) begin
      miscompares++; $display("FAIL wr_hold got %0d cycles of a1/0x20 required 3", hold_cnt - hold_base);
    end
    vectors++;
    if (dr != exp_done_cycle(exp_q.size(), 2) || dr != 22) begin
      miscompares++; $display("FAIL wr_done_cycle got %0d required 22", dr);
    end
    vectors++;
    if (log_q.size() != exp_q.size()) begin
      miscompares++; $display("FAIL wr_len got %0d transfers required %0d", log_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < log_q.size()) begin
      vectors++;
      if (log_q[i] !== exp_q[i]) begin
        miscompares++; $display("FAIL wr_txn%0d got %h required %h", i, log_q[i], exp_q[i]);
      end
    end
    vectors++;
    if (res_addr !== 32'h1111 || res_data !== 32'h2222) begin
      miscompares++; $display("FAIL wr_results got addr=%h data=%h required 1111 2222", res_addr, res_data);
    end
  endtask

`ifdef SRAM_CFG_MASTER_TIMEOUT_EN
  task automatic test_timeout();
    int dr;
    clr_val = 32'h0000_0040; done_val = 32'h1; r5 = 32'h7777; r6 = 32'h8888;
    do_run(32'h44, 32'h55, 32'h6, 1000, -1, 0, -1, -1, 1'b0, dr);
    build_exp(32'h44, 32'h55, 32'h6, PMAX, 1'b0);
    vectors++;
    if (log_q.size() != exp_q.size()) begin
      miscompares++; $display("FAIL to_len got %0d transfers required %0d", log_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < log_q.size()) begin
      vectors++;
      if (log_q[i] !== exp_q[i]) begin
        miscompares++; $display("FAIL to_txn%0d got %h required %h", i, log_q[i], exp_q[i]);
      end
    end
    vectors++;
    if (dr != exp_done_cycle(exp_q.size(), 0)) begin
      miscompares++; $display("FAIL to_done_cycle got %0d required %0d", dr, exp_done_cycle(exp_q.size(), 0));
    end
    vectors++;
    if (error !== 1'b1 || res_addr !== 32'h1111 || res_data !== 32'h2222 || res_status !== 32'h40) begin
      miscompares++;
      $display("FAIL to_results got err=%b addr=%h data=%h status=%h required 1 1111 2222 40", error, res_addr, res_data, res_status);
    end
    clr_val = 32'd0;
    do_run(32'h1, 32'h2, 32'h3, 0, -1, 0, -1, -1, 1'b0, dr);
    vectors++;
    if (err_at1 !== 1'b0 || error !== 1'b0 || res_addr !== 32'h7777) begin
      miscompares++; $display("FAIL to_clear got err_c1=%b err=%b addr=%h required 0 0 7777", err_at1, error, res_addr);
    end
  endtask
`else
  task automatic test_long_poll();
    int dr;
    clr_val = 32'h2; done_val = 32'h3; r5 = $urandom; r6 = $urandom;
    do_run(32'h9, 32'h8, 32'h7, 6, -1, 0, -1, -1, 1'b0, dr);
    build_exp(32'h9, 32'h8, 32'h7, 7, 1'b1);
    vectors++;
    if (log_q.size() != exp_q.size()) begin
      miscompares++; $display("FAIL lp_len got %0d transfers required %0d", log_q.size(), exp_q.size());
    end
    vectors++;
    if (dr != 32) begin miscompares++; $display("FAIL lp_done_cycle got %0d required 32", dr); end
    vectors++;
    if (error !== 1'b0 || res_status !== 32'h3 || res_addr !== r5) begin
      miscompares++; $display("FAIL lp_results got err=%b status=%h addr=%h required 0 3 %h", error, res_status, res_addr, r5);
    end
  endtask
`endif

  task automatic test_start_ignored();
    int dr;
    clr_val = 32'd0; done_val = 32'h1; r5 = 32'hC0DE; r6 = 32'hF00D;
    do_run(32'h31, 32'h32, 32'h33, 3, -1, 0, 5, 20, 1'b1, dr);
    repeat (30) @(negedge avalon_clk);
    build_exp(32'h31, 32'h32, 32'h33, 4, 1'b1);
    vectors++;
    if (done_cnt - done_base != 1) begin
      miscompares++; $display("FAIL si_done_pulses got %0d required 1", done_cnt - done_base);
    end
    vectors++;
    if (log_q.size() != exp_q.size()) begin
      miscompares++; $display("FAIL si_len got %0d transfers required %0d", log_q.size(), exp_q.size());
    end
    vectors++;
    if (dr != 26) begin miscompares++; $display("FAIL si_done_cycle got %0d required 26", dr); end
  endtask

  task automatic test_reset_mid();
    int acts;
    txn_base = txn_idx; poll_base = poll_idx; n_clear = 1000; stall_txn = -1; stall_n = 0;
    @(negedge avalon_clk);
    cfg_sta_addr = 32'h5; cfg_area = 32'h6; cfg_op = 32'h7; start = 1'b1;
    @(negedge avalon_clk);
    start = 1'b0;
    repeat (12) @(negedge avalon_clk);
    vectors++;
    if (chipselect !== 1'b1 || read !== 1'b1 || address !== 3'd7) begin
      miscompares++; $display("FAIL rm_pre_poll got cs=%b rd=%b addr=%0d required 1 1 7", chipselect, read, address);
    end
    #2 reset_n = 1'b0;
    #1;
    vectors++;
    if (chipselect !== 1'b0 || busy !== 1'b0 || read !== 1'b0) begin
      miscompares++; $display("FAIL rm_async got cs=%b busy=%b rd=%b required 0 0 0", chipselect, busy, read);
    end
    @(negedge avalon_clk);
    @(negedge avalon_clk);
    reset_n = 1'b1;
    acts = 0;
    repeat (50) begin
      @(negedge avalon_clk);
      if (chipselect || write || read || busy || done) acts++;
    end
    vectors++;
    if (acts != 0) begin miscompares++; $display("FAIL rm_quiet got %0d active cycles required 0", acts); end
  endtask

  task automatic test_random();
    int dr, nclr, st_txn, st_n;
    logic [31:0] sta, area, op;
    for (int it = 0; it < 8; it++) begin
      sta = $urandom; area = $urandom; op = $urandom;
      nclr = $urandom_range(0, 2);
      st_txn = $urandom_range(0, 9);
      st_n = $urandom_range(0, 3);
      clr_val = $urandom & 32'hFFFF_FFFE;
      done_val = $urandom | 32'h1;
      r5 = $urandom; r6 = $urandom;
      do_run(sta, area, op, nclr, st_txn, st_n, -1, -1, 1'b0, dr);
      build_exp(sta, area, op, nclr + 1, 1'b1);
      vectors++;
      if (log_q.size() != exp_q.size()) begin
        miscompares++; $display("FAIL rnd%0d_len got %0d transfers required %0d", it, log_q.size(), exp_q.size());
      end
      foreach (exp_q[i]) if (i < log_q.size()) begin
        vectors++;
        if (log_q[i] !== exp_q[i]) begin
          miscompares++; $display("FAIL rnd%0d_txn%0d got %h required %h", it, i, log_q[i], exp_q[i]);
        end
      end
      vectors++;
      if (dr != exp_done_cycle(exp_q.size(), st_n)) begin
        miscompares++; $display("FAIL rnd%0d_done_cycle got %0d required %0d", it, dr, exp_done_cycle(exp_q.size(), st_n));
      end
      vectors++;
      if (res_addr !== r5 || res_data !== r6 || res_status !== done_val || error !== 1'b0) begin
        miscompares++;
        $display("FAIL rnd%0d_results got %h %h %h err=%b required %h %h %h 0", it, res_addr, res_data, res_status, error, r5, r6, done_val);
      end
      vectors++;
      if (gap_viol != gap_base) begin miscompares++; $display("FAIL rnd%0d_gap got %0d violations required 0", it, gap_viol - gap_base); end
    end
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_multi_poll();
    test_waitrequest();
`ifdef SRAM_CFG_MASTER_TIMEOUT_EN
    test_timeout();
`else
    test_long_poll();
`endif
    test_start_ignored();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
